axi_interconnect_width_convert_addrsplit: RTL and testbench

//  Parametrised AXI4 AR/AW splitter for wide-slave to narrow-master width conversion.

---
 rtl/axi_interconnect_width_convert_addrsplit_if.sv | 34 +++
 rtl/axi_interconnect_width_convert_addrsplit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_axi_interconnect_width_convert_addrsplit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_interconnect_width_convert_addrsplit_if.sv
// AXI4 address-channel bundle (AR or AW) shared by the slave and master sides
// of the width-converting address splitter.
interface axi_interconnect_width_convert_addrsplit_if #(
  parameter int unsigned WIDTH_ID    = 4,
  parameter int unsigned WIDTH_ADDR  = 32,
  parameter int unsigned WIDTH_AUSER = 1
);
  localparam int unsigned IW = (WIDTH_ID == 0) ? 1 : WIDTH_ID;
  localparam int unsigned UW = (WIDTH_AUSER == 0) ? 1 : WIDTH_AUSER;

  logic [IW-1:0]         id;
  logic [WIDTH_ADDR-1:0] addr;
  logic [7:0]            len;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic [3:0]            region;
  logic                  lock;
  logic [3:0]            cache;
  logic [2:0]            prot;
  logic [3:0]            qos;
  logic [UW-1:0]         user;
  logic                  valid;
  logic                  ready;

  modport master (
    output id, addr, len, size, burst, region, lock, cache, prot, qos, user, valid,
    input  ready
  );

  modport slave (
    input  id, addr, len, size, burst, region, lock, cache, prot, qos, user, valid,
    output ready
  );
endinterface

// File: rtl/axi_interconnect_width_convert_addrsplit.sv
// Splits wide-slave AXI4 address requests into narrow-master bursts (4KB / MAX_MLEN
// splitting, WRAP/FIXED to INCR conversion) and queues a per-burst split descriptor.
module axi_interconnect_width_convert_addrsplit #(
  parameter int unsigned WIDTH_ID    = 4,
  parameter int unsigned WIDTH_ADDR  = 32,
  parameter int unsigned WIDTH_SDATA = 128,
  parameter int unsigned WIDTH_MDATA = 32,
  parameter int unsigned WIDTH_AUSER = 1,
  parameter int unsigned MAX_MLEN    = 256,
  parameter int unsigned INFO_DEPTH  = 4
) (
  input  logic clk_sys,
  input  logic rst_n,
  axi_interconnect_width_convert_addrsplit_if.slave  s_a,
  axi_interconnect_width_convert_addrsplit_if.master m_a,
  output logic [7:0] info_len,
  output logic [7:0] info_offset,
  output logic [2:0] info_ratio,
  output logic [2:0] info_reqsize,
  output logic       info_last,
  output logic       info_valid,
  input  logic       info_ready
);
  localparam int unsigned IW    = (WIDTH_ID == 0) ? 1 : WIDTH_ID;
  localparam int unsigned UW    = (WIDTH_AUSER == 0) ? 1 : WIDTH_AUSER;
  localparam int unsigned AW    = WIDTH_ADDR;
  localparam int unsigned MSIZE = $clog2(WIDTH_MDATA / 8);
  localparam int unsigned PW    = $clog2(INFO_DEPTH);
  localparam int unsigned DW    = 23;
  localparam logic [15:0] MAXL  = 16'(MAX_MLEN);
  localparam logic [AW-1:0] MLOW = AW'((2 ** MSIZE) - 1);
  localparam logic [1:0] B_FIXED = 2'd0;
  localparam logic [1:0] B_INCR  = 2'd1;
  localparam logic [1:0] B_WRAP  = 2'd2;

  if (WIDTH_SDATA < WIDTH_MDATA) begin : g_bad_width
    $error("slave data width must not be narrower than master data width");
  end
  if (WIDTH_ADDR < 12) begin : g_bad_addr
    $error("address width must be at least 12");
  end

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;
  state_t state;

  // master-side registered fields
  logic [IW-1:0] m_id_r;
  logic [AW-1:0] m_addr_r;
  logic [7:0]    m_len_r;
  logic [2:0]    m_size_r;
  logic [1:0]    m_burst_r;
  logic [3:0]    m_region_r;
  logic          m_lock_r;
  logic [3:0]    m_cache_r;
  logic [2:0]    m_prot_r;
  logic [3:0]    m_qos_r;
  logic [UW-1:0] m_user_r;
  logic          s_ready_r;
  logic          last_r;

  // latched request and split-engine state
  logic [7:0]    len_r;
  logic [2:0]    size_r;
  logic [1:0]    burst_r;
  logic [2:0]    ratio_r;
  logic [2:0]    msz_r;
  logic          conv_r;
  logic          pass_r;
  logic [15:0]   rem_r;
  logic [AW-1:0] cur_addr;
  logic          seg_en;
  logic          seg_fix;
  logic [15:0]   seg_rem;
  logic [AW-1:0] jump_addr;

  // request decode from the slave inputs
  logic          s_conv;
  logic [2:0]    s_ratio;
  logic [2:0]    s_msz;
  logic [15:0]   s_rem;
  logic [AW-1:0] wrap_w;
  logic [AW-1:0] wrap_b;
  logic [AW-1:0] wrap_end;
  logic [AW-1:0] addr_mal;
  logic [15:0]   wrap_beats;

  always_comb begin : req_decode
    s_conv     = s_a.size > 3'(MSIZE);
    s_ratio    = s_conv ? (s_a.size - 3'(MSIZE)) : 3'd0;
    s_msz      = s_conv ? 3'(MSIZE) : s_a.size;
    s_rem      = (16'(s_a.len) + 16'd1) << s_ratio;
    wrap_w     = (AW'(s_a.len) + AW'(1)) << s_a.size;
    wrap_b     = s_a.addr & ~(wrap_w - AW'(1));
    wrap_end   = wrap_b + wrap_w;
    addr_mal   = s_a.addr & ~MLOW;
    wrap_beats = 16'((wrap_end - addr_mal) >> MSIZE);
  end

  // next piece: bounded by remaining beats, MAX_MLEN, the 4KB page and the wrap/fixed segment
  logic [AW-1:0] a_al;
  logic [12:0]   to4k;
  logic [15:0]   beats_c;
  logic [AW-1:0] next_addr_c;
  logic          piece_last_c;

  always_comb begin : piece_calc
    a_al    = cur_addr & ~((AW'(1) << msz_r) - AW'(1));
    to4k    = (13'h1000 - {1'b0, a_al[11:0]}) >> msz_r;
    beats_c = rem_r;
    if (MAXL < beats_c) beats_c = MAXL;
    if (16'(to4k) < beats_c) beats_c = 16'(to4k);
    if (seg_en && (seg_rem < beats_c)) beats_c = seg_rem;
    next_addr_c  = a_al + (AW'(beats_c) << msz_r);
    piece_last_c = (rem_r == beats_c);
  end

  // descriptor FIFO
  logic [DW-1:0] mem [INFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          fifo_full_c;
  logic          push_c;
  logic          pop_c;
  logic          m_valid_c;

  assign fifo_full_c = (count == (PW+1)'(INFO_DEPTH));
  assign m_valid_c   = (state == ISSUE) && (!fifo_full_c || info_ready);
  assign push_c      = m_valid_c && m_a.ready;
  assign pop_c       = info_ready && (count != '0);

  always_ff @(posedge clk_sys or negedge rst_n) begin : fifo
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < INFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= {m_len_r, m_addr_r[7:0], ratio_r, size_r, last_r};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign {info_len, info_offset, info_ratio, info_reqsize, info_last} = mem[rd_ptr];
  assign info_valid = (count != '0);

  always_ff @(posedge clk_sys or negedge rst_n) begin : fsm
    if (!rst_n) begin
      state      <= IDLE;
      s_ready_r  <= 1'b0;
      last_r     <= 1'b0;
      m_id_r     <= '0;
      m_addr_r   <= '0;
      m_len_r    <= '0;
      m_size_r   <= '0;
      m_burst_r  <= '0;
      m_region_r <= '0;
      m_lock_r   <= 1'b0;
      m_cache_r  <= '0;
      m_prot_r   <= '0;
      m_qos_r    <= '0;
      m_user_r   <= '0;
      len_r      <= '0;
      size_r     <= '0;
      burst_r    <= '0;
      ratio_r    <= '0;
      msz_r      <= '0;
      conv_r     <= 1'b0;
      pass_r     <= 1'b0;
      rem_r      <= '0;
      cur_addr   <= '0;
      seg_en     <= 1'b0;
      seg_fix    <= 1'b0;
      seg_rem    <= '0;
      jump_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_ready_r && s_a.valid) begin
            s_ready_r  <= 1'b0;
            m_id_r     <= s_a.id;
            m_region_r <= s_a.region;
            m_lock_r   <= s_a.lock;
            m_cache_r  <= s_a.cache;
            m_prot_r   <= s_a.prot;
            m_qos_r    <= s_a.qos;
            m_user_r   <= s_a.user;
            m_size_r   <= s_msz;
            len_r      <= s_a.len;
            size_r     <= s_a.size;
            burst_r    <= s_a.burst;
            ratio_r    <= s_ratio;
            msz_r      <= s_msz;
            conv_r     <= s_conv;
            pass_r     <= !s_conv && (s_a.burst != B_INCR);
            rem_r      <= s_rem;
            cur_addr   <= s_a.addr;
            // FIXED repeats one slave beat; WRAP jumps to the window base once
            seg_en     <= s_conv && ((s_a.burst == B_FIXED) || (s_a.burst == B_WRAP));
            seg_fix    <= s_conv && (s_a.burst == B_FIXED);
            seg_rem    <= (s_a.burst == B_WRAP) ? wrap_beats : (16'd1 << s_ratio);
            jump_addr  <= (s_a.burst == B_WRAP) ? wrap_b : s_a.addr;
            state      <= CALC;
          end else begin
            s_ready_r <= 1'b1;
          end
        end
        CALC: begin
          m_addr_r <= cur_addr;
          if (pass_r) begin
            m_len_r   <= len_r;
            m_burst_r <= burst_r;
            last_r    <= 1'b1;
          end else begin
            m_len_r   <= 8'(beats_c - 16'd1);
            m_burst_r <= conv_r ? B_INCR : burst_r;
            last_r    <= piece_last_c;
            rem_r     <= rem_r - beats_c;
            if (seg_en && (seg_rem == beats_c)) begin
              cur_addr <= jump_addr;
              seg_en   <= seg_fix;
              seg_rem  <= 16'd1 << ratio_r;
            end else begin
              cur_addr <= next_addr_c;
              seg_rem  <= seg_rem - beats_c;
            end
          end
          state <= ISSUE;
        end
        ISSUE: begin
          if (push_c) begin
            if (last_r) begin
              state     <= IDLE;
              s_ready_r <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_a.ready  = s_ready_r;
  assign m_a.valid  = m_valid_c;
  assign m_a.id     = m_id_r;
  assign m_a.addr   = m_addr_r;
  assign m_a.len    = m_len_r;
  assign m_a.size   = m_size_r;
  assign m_a.burst  = m_burst_r;
  assign m_a.region = m_region_r;
  assign m_a.lock   = m_lock_r;
  assign m_a.cache  = m_cache_r;
  assign m_a.prot   = m_prot_r;
  assign m_a.qos    = m_qos_r;
  assign m_a.user   = m_user_r;
endmodule

// File: tb/tb_axi_interconnect_width_convert_addrsplit.sv
// Scoreboard bench for the AXI address splitter: directed requests push expected
// master bursts and descriptors; monitors pop and compare on each handshake/pop.
module tb_axi_interconnect_width_convert_addrsplit;
  localparam logic [1:0] FIXED = 2'd0;
  localparam logic [1:0] INCR  = 2'd1;
  localparam logic [1:0] WRAP  = 2'd2;

  logic clk_sys = 1'b0;
  logic rst_n;
  always #5 clk_sys = ~clk_sys;

  axi_interconnect_width_convert_addrsplit_if #(.WIDTH_ID(4), .WIDTH_ADDR(32), .WIDTH_AUSER(1)) s_if ();
  axi_interconnect_width_convert_addrsplit_if #(.WIDTH_ID(4), .WIDTH_ADDR(32), .WIDTH_AUSER(1)) m_if ();

  logic [7:0] info_len;
  logic [7:0] info_offset;
  logic [2:0] info_ratio;
  logic [2:0] info_reqsize;
  logic       info_last;
  logic       info_valid;
  logic       info_ready;

  axi_interconnect_width_convert_addrsplit #(
    .WIDTH_ID(4), .WIDTH_ADDR(32), .WIDTH_SDATA(128), .WIDTH_MDATA(32),
    .WIDTH_AUSER(1), .MAX_MLEN(256), .INFO_DEPTH(4)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .s_a          (s_if),
    .m_a          (m_if),
    .info_len     (info_len),
    .info_offset  (info_offset),
    .info_ratio   (info_ratio),
    .info_reqsize (info_reqsize),
    .info_last    (info_last),
    .info_valid   (info_valid),
    .info_ready   (info_ready)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [3:0]  region;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic        user;
  } mreq_t;

  typedef struct packed {
    logic [7:0] len;
    logic [7:0] offset;
    logic [2:0] ratio;
    logic [2:0] reqsize;
    logic       last;
  } info_t;

  mreq_t m_q[$];
  info_t i_q[$];
  int vecs = 0;
  int errs = 0;

  logic [3:0] sb_id;
  mreq_t held;
  logic  hold_pend = 1'b0;

  function automatic mreq_t m_actual();
    mreq_t r;
    r.addr = m_if.addr;   r.len = m_if.len;       r.size = m_if.size;
    r.burst = m_if.burst; r.id = m_if.id;         r.region = m_if.region;
    r.lock = m_if.lock;   r.cache = m_if.cache;   r.prot = m_if.prot;
    r.qos = m_if.qos;     r.user = m_if.user;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected master burst plus its descriptor, sideband derived from the current id
  task automatic expect_piece(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                              input logic [1:0] b, input logic lst, input logic [2:0] rat,
                              input logic [2:0] rs);
    mreq_t e;
    info_t f;
    e.addr = a; e.len = l; e.size = sz; e.burst = b; e.id = sb_id;
    e.region = sb_id ^ 4'h5; e.lock = sb_id[0]; e.cache = ~sb_id;
    e.prot = sb_id[2:0]; e.qos = sb_id + 4'd1; e.user = sb_id[1];
    m_q.push_back(e);
    f.len = l; f.offset = a[7:0]; f.ratio = rat; f.reqsize = rs; f.last = lst;
    i_q.push_back(f);
  endtask

  task automatic send_req(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                          input logic [1:0] b);
    logic done;
    done = 1'b0;
    @(posedge clk_sys); #1;
    s_if.valid = 1'b1; s_if.addr = a; s_if.len = l; s_if.size = sz; s_if.burst = b;
    s_if.id = sb_id; s_if.region = sb_id ^ 4'h5; s_if.lock = sb_id[0]; s_if.cache = ~sb_id;
    s_if.prot = sb_id[2:0]; s_if.qos = sb_id + 4'd1; s_if.user = sb_id[1];
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk_sys);
      if (s_if.ready) done = 1'b1;
    end
    if (!done) check("s_handshake_timeout", 64'(s_if.ready), 64'd1);
    @(posedge clk_sys); #1;
    s_if.valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 3000 && (m_q.size() != 0 || i_q.size() != 0); n++) @(negedge clk_sys);
    check("drain_mreq", 64'(m_q.size()), 64'd0);
    check("drain_info", 64'(i_q.size()), 64'd0);
  endtask

  // master request monitor with hold-stability check
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      hold_pend <= 1'b0;
    end else if (m_if.valid) begin
      if (hold_pend) check("m_stable", 64'(m_actual()), 64'(held));
      if (m_if.ready) begin
        hold_pend <= 1'b0;
        if (m_q.size() == 0) check("m_unexpected", 64'(m_actual()), 64'd0);
        else check("m_req", 64'(m_actual()), 64'(m_q.pop_front()));
      end else begin
        hold_pend <= 1'b1;
        held      <= m_actual();
      end
    end else begin
      hold_pend <= 1'b0;
    end
  end

  // descriptor monitor
  always @(negedge clk_sys) begin
    if (rst_n && info_valid && info_ready) begin
      if (i_q.size() == 0) check("info_unexpected", 64'({info_len, info_offset}), 64'd0);
      else check("info", 64'({info_len, info_offset, info_ratio, info_reqsize, info_last}),
                 64'(i_q.pop_front()));
    end
  end

  initial begin
    rst_n = 1'b0;
    s_if.valid = 1'b0; s_if.addr = '0; s_if.len = '0; s_if.size = '0; s_if.burst = '0;
    s_if.id = '0; s_if.region = '0; s_if.lock = 1'b0; s_if.cache = '0; s_if.prot = '0;
    s_if.qos = '0; s_if.user = '0;
    m_if.ready = 1'b1;
    info_ready = 1'b1;
    sb_id = 4'd0;
    repeat (3) @(negedge clk_sys);
    check("rst_s_ready", 64'(s_if.ready), 64'd0);
    check("rst_m_valid", 64'(m_if.valid), 64'd0);
    check("rst_info_valid", 64'(info_valid), 64'd0);
    check("rst_m_addr", 64'(m_if.addr), 64'd0);
    @(posedge clk_sys); #1 rst_n = 1'b1;
    @(posedge clk_sys); @(negedge clk_sys);
    check("s_ready_after_rst", 64'(s_if.ready), 64'd1);

    // single INCR burst, with latency check
    sb_id = 4'd1;
    expect_piece(32'h1000, 8'd15, 3'd2, INCR, 1'b1, 3'd2, 3'd4);
    send_req(32'h1000, 8'd3, 3'd4, INCR);
    @(negedge clk_sys);
    check("lat_calc_cycle", 64'(m_if.valid), 64'd0);
    @(negedge clk_sys);
    check("lat_issue_cycle", 64'(m_if.valid), 64'd1);
    wait_drain();

    // 4KB split
    sb_id = 4'd2;
    expect_piece(32'h0FC0, 8'd15, 3'd2, INCR, 1'b0, 3'd2, 3'd4);
    expect_piece(32'h1000, 8'd15, 3'd2, INCR, 1'b1, 3'd2, 3'd4);
    send_req(32'h0FC0, 8'd7, 3'd4, INCR);

    // MAX_MLEN split
    sb_id = 4'd3;
    for (int k = 0; k < 4; k++)
      expect_piece(32'(k * 32'h400), 8'd255, 3'd2, INCR, (k == 3), 3'd2, 3'd4);
    send_req(32'h0000, 8'd255, 3'd4, INCR);

    // WRAP conversions
    sb_id = 4'd4;
    expect_piece(32'h1030, 8'd3, 3'd2, INCR, 1'b0, 3'd2, 3'd4);
    expect_piece(32'h1000, 8'd11, 3'd2, INCR, 1'b1, 3'd2, 3'd4);
    send_req(32'h1030, 8'd3, 3'd4, WRAP);
    sb_id = 4'd5;
    expect_piece(32'h1000, 8'd15, 3'd2, INCR, 1'b1, 3'd2, 3'd4);
    send_req(32'h1000, 8'd3, 3'd4, WRAP);

    // FIXED conversion
    sb_id = 4'd6;
    expect_piece(32'h2000, 8'd3, 3'd2, INCR, 1'b0, 3'd2, 3'd4);
    expect_piece(32'h2000, 8'd3, 3'd2, INCR, 1'b1, 3'd2, 3'd4);
    send_req(32'h2000, 8'd1, 3'd4, FIXED);

    // narrow WRAP passthrough and narrow INCR 4KB split
    sb_id = 4'd7;
    expect_piece(32'h1008, 8'd3, 3'd2, WRAP, 1'b1, 3'd0, 3'd2);
    send_req(32'h1008, 8'd3, 3'd2, WRAP);
    sb_id = 4'd8;
    expect_piece(32'h0FF8, 8'd1, 3'd2, INCR, 1'b0, 3'd0, 3'd2);
    expect_piece(32'h1000, 8'd1, 3'd2, INCR, 1'b1, 3'd0, 3'd2);
    send_req(32'h0FF8, 8'd3, 3'd2, INCR);
    wait_drain();

    // master backpressure: request held stable
    sb_id = 4'd9;
    m_if.ready = 1'b0;
    expect_piece(32'h3000, 8'd3, 3'd2, INCR, 1'b1, 3'd1, 3'd3);
    send_req(32'h3000, 8'd1, 3'd3, INCR);
    repeat (5) @(negedge clk_sys);
    check("m_valid_stalled", 64'(m_if.valid), 64'd1);
    @(posedge clk_sys); #1 m_if.ready = 1'b1;
    wait_drain();

    // descriptor FIFO full blocks issue until a pop
    info_ready = 1'b0;
    sb_id = 4'd10;
    for (int k = 0; k < 4; k++)
      expect_piece(32'(k * 32'h400), 8'd255, 3'd2, INCR, (k == 3), 3'd2, 3'd4);
    send_req(32'h0000, 8'd255, 3'd4, INCR);
    sb_id = 4'd11;
    expect_piece(32'h1000, 8'd15, 3'd2, INCR, 1'b1, 3'd2, 3'd4);
    send_req(32'h1000, 8'd3, 3'd4, INCR);
    repeat (8) @(negedge clk_sys);
    check("full_m_valid", 64'(m_if.valid), 64'd0);
    check("full_info_valid", 64'(info_valid), 64'd1);
    check("full_pending", 64'(m_q.size()), 64'd1);
    @(posedge clk_sys); #1 info_ready = 1'b1;
    @(negedge clk_sys);
    check("full_pop_m_valid", 64'(m_if.valid), 64'd1);
    @(posedge clk_sys); #1 info_ready = 1'b0;
    @(negedge clk_sys);
    check("after_pop_pending", 64'(m_q.size()), 64'd0);
    check("after_pop_m_valid", 64'(m_if.valid), 64'd0);
    @(posedge clk_sys); #1 info_ready = 1'b1;
    wait_drain();

    // reset while in ISSUE
    sb_id = 4'd12;
    m_if.ready = 1'b0;
    send_req(32'h4000, 8'd0, 3'd4, INCR);
    for (int n = 0; n < 20 && !m_if.valid; n++) @(negedge clk_sys);
    check("pre_rst_m_valid", 64'(m_if.valid), 64'd1);
    @(posedge clk_sys); #1 rst_n = 1'b0;
    @(negedge clk_sys);
    check("mid_rst_m_valid", 64'(m_if.valid), 64'd0);
    check("mid_rst_info_valid", 64'(info_valid), 64'd0);
    check("mid_rst_s_ready", 64'(s_if.ready), 64'd0);
    m_if.ready = 1'b1;
    @(posedge clk_sys); #1 rst_n = 1'b1;
    @(posedge clk_sys); @(negedge clk_sys);
    check("post_rst_s_ready", 64'(s_if.ready), 64'd1);
    check("post_rst_info_valid", 64'(info_valid), 64'd0);

    // recovery after reset
    sb_id = 4'd13;
    expect_piece(32'h0FC0, 8'd15, 3'd2, INCR, 1'b0, 3'd2, 3'd4);
    expect_piece(32'h1000, 8'd15, 3'd2, INCR, 1'b1, 3'd2, 3'd4);
    send_req(32'h0FC0, 8'd7, 3'd4, INCR);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
